// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the 4-digit binary-to-BCD converter.
// State encoding is kept as plain localparam vectors so the converter state
// can be exported on a debug port without casting.
package bcd_pkg;

  // Largest value that fits in four BCD digits.
  localparam int BCD_MAX = 9999;
  localparam int BCD_DIGITS = 4;

  // Pattern shown on the display when the input cannot be represented.
  localparam logic [15:0] BCD_OVF_DEFAULT = 16'hEEEE;

  // Converter state encoding.
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  // Double-dabble correction of one BCD nibble: a digit of 5 or more would
  // reach 10 or more after the next shift, so add 3 first. The operand is at
  // most 9 here, so the sum (at most 12) always fits in the nibble.
  function automatic logic [3:0] nibble_fix(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // Leading-zero mask for a 4-digit BCD value. Bit i is set when digit i and
  // every more significant digit are zero. Digit 0 is always shown, so bit 0
  // is never set.
  function automatic logic [3:0] lz_mask(input logic [15:0] d);
    logic [3:0] m;
    m[3] = (d[15:12] == 4'd0);
    m[2] = m[3] && (d[11:8] == 4'd0);
    m[1] = m[2] && (d[7:4] == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble iteration: correct every BCD nibble in the
// upper 16 bits of the shift register, then shift the whole register left by
// one. The top-level feeds the result back into its register each SHIFT cycle.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int IN_W = 14
) (
  input  logic [IN_W+15:0] i_sr,
  output logic [IN_W+15:0] o_sr
);

  logic [IN_W+15:0] w_fixed;

  // Apply the +3 correction to each of the four BCD digits; binary bits below
  // the BCD field pass through untouched.
  always_comb begin
    w_fixed = i_sr;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      w_fixed[IN_W + 4*d +: 4] = nibble_fix(i_sr[IN_W + 4*d +: 4]);
    end
  end

  assign o_sr = {w_fixed[IN_W+14:0], 1'b0};

endmodule

// File: rtl/bin_to_bcd4.sv
// Sequential binary-to-BCD converter feeding a 4-digit 7-segment driver.
// A value is accepted on in_valid && in_ready and converted with an iterative
// double-dabble, one input bit per clock. The display bus out_hexx only ever
// changes to a complete result, so no partial digits are shown.
// Values above 9999 produce OVF_CODE one cycle after acceptance.
//
// Handshake: a value is taken on any rising edge where in_valid and in_ready
// are both high; in_ready is high exactly when the converter is idle, and
// in_valid/in_bin are ignored while it is busy. out_valid is a single-cycle
// pulse marking that out_hexx (and overflow) have just been updated; there is
// no back-pressure on the output side.
//
// Optional build macro: BIN_TO_BCD4_LZB_EN adds the out_lz leading-zero mask.
// IN_W is expected to lie in 4..16.
module bin_to_bcd4
  import bcd_pkg::*;
#(
  parameter int          IN_W     = 14,
  parameter logic [15:0] OVF_CODE = BCD_OVF_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_bin,
  output logic [15:0]     out_hexx,
  output logic            out_valid,
  output logic            overflow,
`ifdef BIN_TO_BCD4_LZB_EN
  output logic [3:0]      out_lz,
`endif
  output logic [0:0]      dbg_state
);

  localparam int SR_W  = 16 + IN_W;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [SR_W-1:0]  MAX_SR   = SR_W'(BCD_MAX);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  logic [SR_W-1:0]  r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_hexx;
  logic             r_out_valid;
  logic             r_overflow;

  logic [SR_W-1:0]  w_in_ext;
  logic [SR_W-1:0]  w_step;
  logic             w_accept;
  logic             w_in_ovf;
  logic             w_ovf_load;
  logic             w_last;
  logic             w_done;

  // Zero-extended input doubles as the initial shift-register image.
  assign w_in_ext   = {16'b0, in_bin};
  assign w_in_ovf   = (w_in_ext > MAX_SR);
  assign w_accept   = in_valid && (r_state == ST_IDLE);
  assign w_ovf_load = w_accept && w_in_ovf;
  assign w_last     = (r_cnt == CNT_ONE);
  assign w_done     = (r_state == ST_SHIFT) && w_last;

  bcd_dabble_step #(
    .IN_W (IN_W)
  ) u_step (
    .i_sr (r_sr),
    .o_sr (w_step)
  );

  // Converter FSM: load on acceptance, iterate IN_W times, publish the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_hexx      <= 16'h0000;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_in_ovf) begin
              // Not representable: show the overflow pattern immediately.
              r_hexx      <= OVF_CODE;
              r_overflow  <= 1'b1;
              r_out_valid <= 1'b1;
            end else begin
              r_sr    <= w_in_ext;
              r_cnt   <= CNT_LOAD;
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          r_sr  <= w_step;
          r_cnt <= r_cnt - CNT_ONE;
          if (w_last) begin
            // Final iteration: the BCD field of this step is the answer.
            r_hexx      <= w_step[SR_W-1:IN_W];
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef BIN_TO_BCD4_LZB_EN
  logic [3:0] r_lz;

  // Leading-zero mask, updated in the same cycle as out_hexx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lz <= 4'b0000;
    end else if (w_ovf_load) begin
      r_lz <= 4'b0000;
    end else if (w_done) begin
      r_lz <= lz_mask(w_step[SR_W-1:IN_W]);
    end
  end

  assign out_lz = r_lz;
`endif

  assign in_ready  = (r_state == ST_IDLE);
  assign out_hexx  = r_hexx;
  assign out_valid = r_out_valid;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bin_to_bcd4.sv
// Self-checking bench for bin_to_bcd4: table of vectors, hand-written
// back-to-back and mid-conversion reset sequences, and a few random values.
// Expected results go into exp_q when a value is offered; the monitor pops
// and compares whenever out_valid pulses.
module tb_bin_to_bcd4;

  localparam int IN_W = 14;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_bin;
  logic [15:0]     out_hexx;
  logic            out_valid;
  logic            overflow;
  logic [0:0]      dbg_state;
`ifdef BIN_TO_BCD4_LZB_EN
  logic [3:0]      out_lz;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Expected record: [20]=overflow, [19:16]=leading-zero mask, [15:0]=digits.
  logic [20:0] exp_q[$];

  typedef struct {
    logic [15:0] bin;
    logic [15:0] hex;
    logic        ovf;
    logic [3:0]  lz;
  } vec_t;

  vec_t tbl[12];

  bin_to_bcd4 #(
    .IN_W     (IN_W),
    .OVF_CODE (16'hEEEE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_hexx  (out_hexx),
    .out_valid (out_valid),
    .overflow  (overflow),
`ifdef BIN_TO_BCD4_LZB_EN
    .out_lz    (out_lz),
`endif
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model by decimal division (overflow above 9999).
  function automatic logic [20:0] model(input int v);
    logic [15:0] h;
    logic [3:0]  lz;
    if (v > 9999) return {1'b1, 4'b0000, 16'hEEEE};
    h  = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    lz = {v < 1000, v < 100, v < 10, 1'b0};
    return {1'b0, lz, h};
  endfunction

  // Scoreboard monitor: sample away from the active edge.
  always @(negedge clk) begin
    logic [20:0] e;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got out_hexx 0x%0h with no pending value at %0t",
                 out_hexx, $time);
      end else begin
        e = exp_q.pop_front();
        chk("out_hexx", 32'(out_hexx), 32'(e[15:0]));
        chk("overflow", 32'(overflow), 32'(e[20]));
`ifdef BIN_TO_BCD4_LZB_EN
        chk("out_lz", 32'(out_lz), 32'(e[19:16]));
`endif
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", 32'(in_ready), 32'd1);
  endtask

  // Offer one value, then check handshake timing and the single-cycle pulse.
  task automatic send(input logic [15:0] v, input logic [20:0] e);
    int  n;
    bit  busy_ok;
    wait_ready();
    in_valid = 1'b1;
    in_bin   = v[IN_W-1:0];
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    in_bin   = IN_W'($urandom_range(0, 16383));
    n = 1;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && n < IN_W + 10) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), e[20] ? 32'd1 : 32'(IN_W + 1));
    chk("ready_low_while_busy", 32'(busy_ok), 32'd1);
    chk("ready_at_result", 32'(in_ready), 32'd1);
    if (!e[20]) begin
      @(negedge clk);
      chk("out_valid_one_cycle", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    int n;
    int r;

    tbl[0]  = '{16'd1234,  16'h1234, 1'b0, 4'b0000};
    tbl[1]  = '{16'd0,     16'h0000, 1'b0, 4'b1110};
    tbl[2]  = '{16'd9999,  16'h9999, 1'b0, 4'b0000};
    tbl[3]  = '{16'd10000, 16'hEEEE, 1'b1, 4'b0000};
    tbl[4]  = '{16'd5,     16'h0005, 1'b0, 4'b1110};
    tbl[5]  = '{16'd42,    16'h0042, 1'b0, 4'b1100};
    tbl[6]  = '{16'd16383, 16'hEEEE, 1'b1, 4'b0000};
    tbl[7]  = '{16'd1,     16'h0001, 1'b0, 4'b1110};
    tbl[8]  = '{16'd10,    16'h0010, 1'b0, 4'b1100};
    tbl[9]  = '{16'd100,   16'h0100, 1'b0, 4'b1000};
    tbl[10] = '{16'd1000,  16'h1000, 1'b0, 4'b0000};
    tbl[11] = '{16'd9990,  16'h9990, 1'b0, 4'b0000};

    // Reset
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bin   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_hexx", 32'(out_hexx), 32'h0000);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'd0);
`ifdef BIN_TO_BCD4_LZB_EN
    chk("rst_out_lz", 32'(out_lz), 32'd0);
`endif

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].bin, {tbl[i].ovf, tbl[i].lz, tbl[i].hex});
    end

    // Back-to-back with in_valid held high; in_bin changes while busy
    wait_ready();
    in_valid = 1'b1;
    in_bin   = IN_W'(42);
    exp_q.push_back({1'b0, 4'b1100, 16'h0042});
    @(negedge clk);
    in_bin = IN_W'(99);
    n = 1;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_latency", 32'(n), 32'(IN_W + 1));
    chk("b2b_ready_with_result", 32'(in_ready), 32'd1);
    in_bin = IN_W'(7);
    exp_q.push_back({1'b0, 4'b1110, 16'h0007});
    @(negedge clk);
    chk("b2b_second_accepted", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    in_bin   = IN_W'(3);
    n = 1;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_second_gap", 32'(n), 32'(IN_W + 1));
    @(negedge clk);

    // Reset in the middle of a conversion
    wait_ready();
    in_valid = 1'b1;
    in_bin   = IN_W'(8888);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_hexx", 32'(out_hexx), 32'h0000);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rel_state", 32'(dbg_state), 32'd0);
    repeat (20) @(negedge clk);
    chk("mid_rel_out_hexx", 32'(out_hexx), 32'h0000);

    // Random values, including occasional overflow
    for (int i = 0; i < 8; i++) begin
      r = (i % 4 == 3) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
      send(16'(r), model(r));
    end

    // Drain and report
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
